wb_req_arbiter: RTL

- Round-robin arbiter sharing one pipelined Wishbone slave port between NREQ local requesters.
- The slave is one of the team's generated register banks (stall/ack handshake, err/rty tied low).
- One transaction is in flight at a time.
- A watchdog aborts transactions the slave never acknowledges, so a requester never hangs.

---
 rtl/wb_req_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_req_arbiter
// Description : Round-robin arbiter sharing one pipelined Wishbone master port
//               between NREQ local requesters, one transaction at a time,
//               with a watchdog that aborts unacknowledged transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   req_we_i,
  input  logic [NREQ*AW-1:0] req_adr_i,
  input  logic [NREQ*32-1:0] req_dat_i,
  input  logic [NREQ*4-1:0] req_sel_i,
  output logic [NREQ-1:0]   req_ack_o,
  output logic [NREQ-1:0]   req_err_o,
  output logic [31:0]       req_dat_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_stall_i,
  input  logic [31:0]       wb_dat_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value during the last permitted cycle; expiry happens at its edge.
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   last_grant, last_nx;
  logic [TW-1:0]   cnt, cnt_nx;
  logic            cyc_nx, stb_nx, we_nx, busy_nx, to_nx;
  logic [AW-1:0]   adr_nx;
  logic [3:0]      sel_nx;
  logic [31:0]     wdat_nx, rdat_nx;
  logic [NREQ-1:0] ack_nx, err_nx;

  logic [AW-1:0]   adr_arr [NREQ];
  logic [31:0]     dat_arr [NREQ];
  logic [3:0]      sel_arr [NREQ];

  logic [NREQ-1:0] elig;
  logic [GW-1:0]   pick;
  logic [NREQ-1:0] grant_oh;
  logic            resp, accept, expire;

  // Split the flat per-requester buses into indexable arrays.
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign adr_arr[i] = req_adr_i[i*AW +: AW];
      assign dat_arr[i] = req_dat_i[i*32 +: 32];
      assign sel_arr[i] = req_sel_i[i*4 +: 4];
    end
  endgenerate

  // First eligible requester searching upward from last + 1, wrapping.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] el,
                                            input logic [GW-1:0]   last);
    logic [GW-1:0] r;
    logic          hit;
    int            cand;
    r   = '0;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!hit && el[GW'(cand)]) begin
        hit = 1'b1;
        r   = GW'(cand);
      end
    end
    return r;
  endfunction

  // The requester acked this cycle sits out so a late req_i drop is harmless.
  assign elig     = req_i & ~req_ack_o;
  assign pick     = rr_pick(elig, last_grant);
  assign grant_oh = NREQ'(1) << last_grant;
  assign resp     = wb_ack_i | wb_err_i;
  assign accept   = ((state == S_ISSUE) && !wb_stall_i) || (state == S_WAIT);
  assign expire   = (TIMEOUT != 0) && (cnt == TO_LAST);

  // State register and all registered outputs; reset forces the bus idle at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      last_grant <= GW'(NREQ - 1);
      cnt        <= '0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_sel_o   <= '0;
      wb_dat_o   <= '0;
      req_ack_o  <= '0;
      req_err_o  <= '0;
      req_dat_o  <= '0;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_nx;
      cnt        <= cnt_nx;
      wb_cyc_o   <= cyc_nx;
      wb_stb_o   <= stb_nx;
      wb_we_o    <= we_nx;
      wb_adr_o   <= adr_nx;
      wb_sel_o   <= sel_nx;
      wb_dat_o   <= wdat_nx;
      req_ack_o  <= ack_nx;
      req_err_o  <= err_nx;
      req_dat_o  <= rdat_nx;
      busy_o     <= busy_nx;
      timeout_o  <= to_nx;
    end
  end

  // Next-state and next-output logic; ack/err beat watchdog expiry on the same edge.
  always_comb begin
    state_nx = state;
    last_nx  = last_grant;
    cnt_nx   = cnt;
    cyc_nx   = wb_cyc_o;
    stb_nx   = wb_stb_o;
    we_nx    = wb_we_o;
    adr_nx   = wb_adr_o;
    sel_nx   = wb_sel_o;
    wdat_nx  = wb_dat_o;
    ack_nx   = '0;
    err_nx   = '0;
    rdat_nx  = '0;
    busy_nx  = busy_o;
    to_nx    = timeout_o;

    case (state)
      S_IDLE: begin
        if (|elig) begin
          last_nx  = pick;
          we_nx    = req_we_i[pick];
          adr_nx   = adr_arr[pick];
          sel_nx   = sel_arr[pick];
          wdat_nx  = dat_arr[pick];
          cyc_nx   = 1'b1;
          stb_nx   = 1'b1;
          busy_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (accept && resp) begin
          cyc_nx   = 1'b0;
          stb_nx   = 1'b0;
          busy_nx  = 1'b0;
          ack_nx   = grant_oh;
          err_nx   = grant_oh & {NREQ{wb_err_i}};
          rdat_nx  = wb_dat_i;
          state_nx = S_IDLE;
        end else if (expire) begin
          cyc_nx   = 1'b0;
          stb_nx   = 1'b0;
          busy_nx  = 1'b0;
          ack_nx   = grant_oh;
          err_nx   = grant_oh;
          to_nx    = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt + TW'(1);
          if (accept) begin
            stb_nx   = 1'b0;
            state_nx = S_WAIT;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
